addsub_share_arb: RTL and testbench

//   Shares one N-bit add/subtract datapath between NREQ requesters.

---
 rtl/addsub_pkg.sv | 43 ++++
 rtl/addsub_share_arb_rr_arbiter.sv | 52 +++++
 rtl/cla_adder.sv | 49 ++++
 rtl/addsub_share_arb.sv | 125 ++++++++++++
 tb/tb_addsub_share_arb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and helpers for the add/subtract arbiter slice:
//               opcode values, result-slot state encoding and the round-robin
//               grant search.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;

  // Widest requester vector the grant search handles
  localparam int RR_MAX = 16;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  // One-hot grant for the first valid requester at or above ptr, wrapping at nreq
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                input logic [3:0]        ptr,
                                                input int                nreq);
    logic [RR_MAX-1:0] r_pick;
    logic              found;
    int                idx;
    r_pick = '0;
    found  = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (k < nreq) && valid[idx[3:0]]) begin
        r_pick[idx[3:0]] = 1'b1;
        found            = 1'b1;
      end
    end
    return r_pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_share_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Owns the priority pointer, which moves to
//               one past the grantee whenever advance is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import addsub_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant_onehot,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     r_ptr;
  logic [RR_MAX-1:0] w_valid_ext;
  logic [3:0]        w_ptr_ext;
  logic [RR_MAX-1:0] w_pick;

  // Grant search and one-hot to index encode
  always_comb begin
    w_valid_ext             = '0;
    w_valid_ext[NREQ-1:0]   = req_valid;
    w_ptr_ext               = '0;
    w_ptr_ext[PW-1:0]       = r_ptr;
    w_pick                  = rr_pick(w_valid_ext, w_ptr_ext, NREQ);
    grant_onehot            = w_pick[NREQ-1:0];
    grant_idx               = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (w_pick[i]) grant_idx = grant_idx | PW'(i);
    end
  end

  // Pointer moves past the grantee on each accepted operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder
// Description : N-bit carry-lookahead adder built from 4-bit lookahead groups
//               chained group to group. N must be a multiple of 4.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int NGRP = N / 4;

  logic [NGRP:0] w_c;

  assign w_c[0] = cin;
  assign cout   = w_c[NGRP];

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [3:0] w_p;
      logic [3:0] w_g;
      logic [3:0] w_ci;

      assign w_p = a[4*gi +: 4] ^ b[4*gi +: 4];
      assign w_g = a[4*gi +: 4] & b[4*gi +: 4];

      // All in-group carries are formed directly from the group carry-in
      assign w_ci[0] = w_c[gi];
      assign w_ci[1] = w_g[0] | (w_p[0] & w_ci[0]);
      assign w_ci[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_ci[0]);
      assign w_ci[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                     | (w_p[2] & w_p[1] & w_p[0] & w_ci[0]);
      assign w_c[gi+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                       | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_ci[0]);

      assign s[4*gi +: 4] = w_p ^ w_ci;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/addsub_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : addsub_share_arb
// Description : One shared add/subtract datapath serving NREQ requesters via
//               round-robin arbitration and a one-entry registered result slot.
//               Optional macro ADDSUB_SHARE_ARB_OVF_EN adds the resp_ovf
//               signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_share_arb
  import addsub_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_sub,
  input  logic [NREQ*N-1:0]       req_a,
  input  logic [NREQ*N-1:0]       req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [N-1:0]            resp_s,
  output logic                    resp_cout
`ifdef ADDSUB_SHARE_ARB_OVF_EN
  ,
  output logic                    resp_ovf
`endif
);

  localparam int IW = $clog2(NREQ);

  slot_state_t     r_state;
  logic [IW-1:0]   r_id;
  logic [N-1:0]    r_s;
  logic            r_cout;
  logic            w_slot_free;
  logic            w_accept;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;
  logic [N-1:0]    w_b_eff;
  logic            w_sub;
  logic [N-1:0]    w_sum;
  logic            w_cout;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .advance      (w_accept),
    .grant_onehot (w_grant),
    .grant_idx    (w_gidx)
  );

  // Handshake and AND-OR operand mux driven by the one-hot grant
  always_comb begin
    w_slot_free = (r_state == ST_EMPTY) | resp_ready;
    req_ready   = w_grant & {NREQ{w_slot_free}};
    w_accept    = |(req_valid & req_ready);
    w_a         = '0;
    w_b         = '0;
    w_sub       = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a   = w_a | req_a[i*N +: N];
        w_b   = w_b | req_b[i*N +: N];
        w_sub = w_sub | (req_sub[i] == ADDSUB_OP_SUB);
      end
    end
    w_b_eff = w_sub ? ~w_b : w_b;
  end

  // Subtract is a + ~b + 1, so the carry-in is the subtract flag itself
  cla_adder #(.N(N)) u_add (
    .a    (w_a),
    .b    (w_b_eff),
    .cin  (w_sub),
    .s    (w_sum),
    .cout (w_cout)
  );

`ifdef ADDSUB_SHARE_ARB_OVF_EN
  logic r_ovf;
  logic w_ovf;
  assign w_ovf    = (w_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != w_a[N-1]);
  assign resp_ovf = r_ovf;
`endif

  // Result slot state machine; the slot loads on every accept, including drain+accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_id    <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
`ifdef ADDSUB_SHARE_ARB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_state <= ST_FULL;
        r_id    <= w_gidx;
        r_s     <= w_sum;
        r_cout  <= w_cout;
`ifdef ADDSUB_SHARE_ARB_OVF_EN
        r_ovf   <= w_ovf;
`endif
      end else if ((r_state == ST_FULL) && resp_ready) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign resp_valid = (r_state == ST_FULL);
  assign resp_id    = r_id;
  assign resp_s     = r_s;
  assign resp_cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_addsub_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_share_arb
// Description : Self-checking bench for addsub_share_arb (N=32, NREQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_share_arb;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [N-1:0]      resp_s;
  logic              resp_cout;
`ifdef ADDSUB_SHARE_ARB_OVF_EN
  logic              resp_ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;

  addsub_share_arb #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub    (req_sub),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_s     (resp_s),
    .resp_cout  (resp_cout)
`ifdef ADDSUB_SHARE_ARB_OVF_EN
    ,
    .resp_ovf   (resp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: slot contents, priority pointer
  bit          m_full;
  int          m_ptr;
  int          m_id;
  logic [31:0] m_s;
  bit          m_cout;
  bit          m_ovf;

  // Every cycle: compare DUT against the model, then advance the model across the coming edge
  always @(negedge clk) begin : compare
    int          g;
    int          j;
    bit          free;
    logic [3:0]  er;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] wide;
    if (!rst_n) begin
      m_full = 0; m_ptr = 0; m_id = 0; m_s = '0; m_cout = 0; m_ovf = 0;
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst resp_s", 64'(resp_s), 64'd0);
    end else begin
      chk("mdl resp_valid", 64'(resp_valid), 64'(m_full));
      if (m_full) begin
        chk("mdl resp_id", 64'(resp_id), 64'(m_id));
        chk("mdl resp_s", 64'(resp_s), 64'(m_s));
        chk("mdl resp_cout", 64'(resp_cout), 64'(m_cout));
`ifdef ADDSUB_SHARE_ARB_OVF_EN
        chk("mdl resp_ovf", 64'(resp_ovf), 64'(m_ovf));
`endif
      end
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[j[1:0]]) g = j;
      end
      free = !m_full || resp_ready;
      er   = (g >= 0 && free) ? (4'b0001 << g) : 4'b0000;
      chk("mdl req_ready", 64'(req_ready), 64'(er));
      if (g >= 0 && free) begin
        a = req_a[g*N +: N];
        b = req_b[g*N +: N];
        if (req_sub[g[1:0]]) begin
          m_s    = a - b;
          m_cout = (a >= b);
          m_ovf  = (a[31] != b[31]) && (m_s[31] != a[31]);
        end else begin
          wide   = {1'b0, a} + {1'b0, b};
          m_s    = wide[31:0];
          m_cout = wide[32];
          m_ovf  = (a[31] == b[31]) && (m_s[31] != a[31]);
        end
        m_full = 1;
        m_id   = g;
        m_ptr  = (g + 1) % NREQ;
      end else if (m_full && resp_ready) begin
        m_full = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_sub[i]      = s;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b1;
    req_a = '0; req_b = '0; req_sub = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_id", 64'(resp_id), 64'd0);
    chk("reset resp_cout", 64'(resp_cout), 64'd0);

    // Single add from requester 0
    cyc(); set_op(0, 32'h5, 32'h3, 1'b0); req_valid = 4'b0001;
    @(negedge clk); chk("t1 req_ready", 64'(req_ready), 64'h1);
    cyc(); req_valid = 4'b0000;
    @(negedge clk);
    chk("t1 resp_valid", 64'(resp_valid), 64'd1);
    chk("t1 resp_id", 64'(resp_id), 64'd0);
    chk("t1 resp_s", 64'(resp_s), 64'h8);
    chk("t1 resp_cout", 64'(resp_cout), 64'd0);

    // Subtract with borrow, then subtract with signed overflow
    cyc(); set_op(2, 32'h3, 32'h5, 1'b1); req_valid = 4'b0100;
    @(negedge clk); chk("t2 req_ready", 64'(req_ready), 64'h4);
    cyc(); req_valid = 4'b0000;
    @(negedge clk);
    chk("t2 resp_s", 64'(resp_s), 64'hFFFF_FFFE);
    chk("t2 resp_cout", 64'(resp_cout), 64'd0);
    chk("t2 resp_id", 64'(resp_id), 64'd2);
`ifdef ADDSUB_SHARE_ARB_OVF_EN
    chk("t2 resp_ovf", 64'(resp_ovf), 64'd0);
`endif
    cyc(); set_op(2, 32'h8000_0000, 32'h1, 1'b1); req_valid = 4'b0100;
    cyc(); req_valid = 4'b0000;
    @(negedge clk);
    chk("t2b resp_s", 64'(resp_s), 64'h7FFF_FFFF);
    chk("t2b resp_cout", 64'(resp_cout), 64'd1);
`ifdef ADDSUB_SHARE_ARB_OVF_EN
    chk("t2b resp_ovf", 64'(resp_ovf), 64'd1);
`endif

    // Fairness from a fresh pointer: all four requesters continuously valid
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h100 * (i + 1), 32'(i + 1), i[0]);
    req_valid = 4'b1111; resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3 grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("t3 resp_valid", 64'(resp_valid), 64'd1);
        chk("t3 resp_id", 64'(resp_id), 64'((k - 1) % 4));
      end
      cyc();
    end

    // Back-pressure: slot holds requester 3's result (0x400 - 4)
    req_valid = 4'b0000; resp_ready = 1'b0;
    @(negedge clk); chk("t4 held s", 64'(resp_s), 64'h3FC);
    cyc(); req_valid = 4'b0010;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("t4 bp req_ready", 64'(req_ready), 64'h0);
      chk("t4 bp resp_s", 64'(resp_s), 64'h3FC);
      chk("t4 bp resp_id", 64'(resp_id), 64'd3);
      chk("t4 bp resp_cout", 64'(resp_cout), 64'd1);
      cyc();
    end
    resp_ready = 1'b1;
    @(negedge clk); chk("t4 drain+accept", 64'(req_ready), 64'h2);
    cyc(); req_valid = 4'b0000;
    @(negedge clk);
    chk("t4 full after", 64'(resp_valid), 64'd1);
    chk("t4 resp_id", 64'(resp_id), 64'd1);
    chk("t4 resp_s", 64'(resp_s), 64'h1FE);

    // Wrap and skip: move pointer to 3 via requester 2, then only requester 1 valid
    cyc(); req_valid = 4'b0100;
    @(negedge clk); chk("t5 req2 grant", 64'(req_ready), 64'h4);
    cyc(); set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0); req_valid = 4'b0010;
    @(negedge clk); chk("t5 wrap grant", 64'(req_ready), 64'h2);
    cyc(); req_valid = 4'b0110;
    @(negedge clk);
    chk("t5 carry s", 64'(resp_s), 64'h0);
    chk("t5 carry cout", 64'(resp_cout), 64'd1);
    chk("t5 resp_id", 64'(resp_id), 64'd1);
    chk("t5 ptr=2", 64'(req_ready), 64'h4);

    // Reset mid-burst clears the slot without a clock edge
    cyc(); req_valid = 4'b1111;
    cyc();
    cyc();
    chk("t6 full pre", 64'(resp_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 async clear", 64'(resp_valid), 64'd0);
    chk("t6 async id", 64'(resp_id), 64'd0);
    cyc(); rst_n = 1'b1; req_valid = 4'b1010;
    @(negedge clk); chk("t6 first grant", 64'(req_ready), 64'h2);
    cyc(); req_valid = 4'b0000;
    @(negedge clk); chk("t6 resp_id", 64'(resp_id), 64'd1);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
